lfsr_scrambler_par: RTL and testbench

Parametrised additive (synchronous) LFSR scrambler for the TX serdes path. It processes DATA_W bits per clock over framed bursts of FRAME_LEN words. The LFSR is reseeded at every frame start. A per-frame bypass mode passes data through unscrambled. The block sits between the framer and the serializer, with valid/ready handshakes on both sides and a start/done frame handshake toward the TX controller.

---
 rtl/lfsr_scrambler_par.sv | 148 ++++++++++++++
 tb/tb_lfsr_scrambler_par.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_scrambler_par.sv
// Additive LFSR scrambler for the TX serdes path: DATA_W keystream bits per word,
// reseeded at each frame start, with a per-frame bypass and a one-entry output register.
module lfsr_scrambler_par #(
    parameter int                LFSR_W    = 12,
    parameter logic [LFSR_W-1:0] TAPS      = 12'hC81,
    parameter logic [LFSR_W-1:0] SEED      = 12'h89F,
    parameter int                DATA_W    = 8,
    parameter int                FRAME_LEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              bypass,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int                CNT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_scrambler_par: SEED must be nonzero");
    end
    if (TAPS[LFSR_W-1] != 1'b1) begin : g_bad_taps
        $error("lfsr_scrambler_par: TAPS must include the top state bit");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              bypass_q, bypass_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] keystream;
    logic [LFSR_W-1:0] lfsr_walk;
    logic [LFSR_W-1:0] lfsr_adv;
    logic              accept;

    // Unroll DATA_W serial steps; bit i of the word pairs with the i-th feedback bit.
    always_comb begin
        keystream = '0;
        lfsr_walk = lfsr_q;
        for (int i = 0; i < DATA_W; i++) begin
            keystream[i] = ^(lfsr_walk & TAPS);
            lfsr_walk    = {lfsr_walk[LFSR_W-2:0], keystream[i]};
        end
        lfsr_adv = lfsr_walk;
    end

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        count_d     = count_q;
        bypass_d    = bypass_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        in_ready    = 1'b0;
        accept      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A start coinciding with the done pulse belongs to the old frame.
                if (start && !done_q) begin
                    lfsr_d   = SEED;
                    count_d  = '0;
                    bypass_d = bypass;
                    state_d  = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                in_ready = !out_valid_q || out_ready;
                accept   = in_valid && in_ready;
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
                if (accept) begin
                    out_data_d  = bypass_q ? in_data : (in_data ^ keystream);
                    out_valid_d = 1'b1;
                    lfsr_d      = lfsr_adv;
                    count_d     = count_q + CNT_W'(1);
                    out_last_d  = (count_q == LAST_IDX);
                    if (count_q == LAST_IDX) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (out_valid_q && out_ready && out_last_q) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    out_data_d  = '0;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lfsr_q      <= SEED;
            count_q     <= '0;
            bypass_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            count_q     <= count_d;
            bypass_q    <= bypass_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_lfsr_scrambler_par.sv
// Bench for lfsr_scrambler_par: a small 3-bit configuration checked against hand-computed
// vectors, and the default configuration chained into a descrambler under random stalls.
module tb_lfsr_scrambler_par;

    localparam logic [11:0] D_TAPS = 12'hC81;
    localparam logic [11:0] D_SEED = 12'h89F;
    localparam int          D_LEN  = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Small configuration signals
    logic       sm_start = 1'b0, sm_bypass = 1'b0, sm_in_valid = 1'b0, sm_out_ready = 1'b1;
    logic [6:0] sm_in_data = '0;
    logic [6:0] sm_out_data;
    logic       sm_in_ready, sm_out_valid, sm_out_last, sm_busy, sm_done;

    // Default configuration: scrambler (def) feeding descrambler (lb)
    logic       def_start = 1'b0, def_bypass = 1'b0, def_in_valid = 1'b0;
    logic [7:0] def_in_data = '0;
    logic [7:0] def_out_data, lb_out_data;
    logic       def_in_ready, def_out_valid, def_out_last, def_busy, def_done;
    logic       lb_bypass = 1'b0, lb_out_ready = 1'b1;
    logic       lb_in_ready, lb_out_valid, lb_out_last, lb_busy, lb_done;

    lfsr_scrambler_par #(
        .LFSR_W(3), .TAPS(3'b110), .SEED(3'b001), .DATA_W(7), .FRAME_LEN(2)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .start(sm_start), .bypass(sm_bypass),
        .in_data(sm_in_data), .in_valid(sm_in_valid), .in_ready(sm_in_ready),
        .out_data(sm_out_data), .out_valid(sm_out_valid), .out_ready(sm_out_ready),
        .out_last(sm_out_last), .busy(sm_busy), .done(sm_done)
    );

    lfsr_scrambler_par u_def (
        .clk(clk), .rst_n(rst_n), .start(def_start), .bypass(def_bypass),
        .in_data(def_in_data), .in_valid(def_in_valid), .in_ready(def_in_ready),
        .out_data(def_out_data), .out_valid(def_out_valid), .out_ready(lb_in_ready),
        .out_last(def_out_last), .busy(def_busy), .done(def_done)
    );

    lfsr_scrambler_par u_lb (
        .clk(clk), .rst_n(rst_n), .start(def_start), .bypass(lb_bypass),
        .in_data(def_out_data), .in_valid(def_out_valid), .in_ready(lb_in_ready),
        .out_data(lb_out_data), .out_valid(lb_out_valid), .out_ready(lb_out_ready),
        .out_last(lb_out_last), .busy(lb_busy), .done(lb_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference keystream model: returns {next_state, keystream_byte}
    function automatic logic [19:0] ks_step(input logic [11:0] s);
        logic [7:0] ks;
        logic       f;
        ks = '0;
        for (int i = 0; i < 8; i++) begin
            f = 1'b0;
            for (int k = 0; k < 12; k++) begin
                if (D_TAPS[k]) f = f ^ s[k];
            end
            ks[i] = f;
            s = {s[10:0], f};
        end
        return {s, ks};
    endfunction

    // ---------------- scoreboard / monitor for the chained default pair ----------------
    logic [7:0] def_exp_q[$];
    logic [7:0] lb_exp_q[$];
    logic       mon_en = 1'b0;
    logic       rand_en = 1'b0;
    int         def_word_idx = 0, lb_words = 0, def_done_cnt = 0, lb_done_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            lb_out_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [7:0] exp_w;
        if (mon_en) begin
            if (def_out_valid && lb_in_ready) begin
                if (def_exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL def_extra_word: got %0h expected none", def_out_data);
                end else begin
                    exp_w = def_exp_q.pop_front();
                    check("def_out_data", 32'(def_out_data), 32'(exp_w));
                    check("def_out_last", 32'(def_out_last), 32'(def_word_idx == D_LEN - 1));
                end
                def_word_idx++;
            end
            if (def_out_valid && !lb_in_ready) begin
                check("def_in_ready_stall", 32'(def_in_ready), 32'd0);
            end
            if (prev_stall) begin
                check("def_hold_data", 32'(def_out_data), 32'(prev_data));
                check("def_hold_last", 32'(def_out_last), 32'(prev_last));
            end
            prev_stall = def_out_valid && !lb_in_ready;
            prev_data  = def_out_data;
            prev_last  = def_out_last;
            if (lb_out_valid && lb_out_ready) begin
                if (lb_exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL lb_extra_word: got %0h expected none", lb_out_data);
                end else begin
                    exp_w = lb_exp_q.pop_front();
                    check("lb_recovered", 32'(lb_out_data), 32'(exp_w));
                end
                lb_words++;
            end
            if (def_done) def_done_cnt++;
            if (lb_done) lb_done_cnt++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- small-config drivers ----------------
    typedef struct {
        logic       bp;
        logic [6:0] d0, d1, e0, e1;
    } sm_vec_t;

    task automatic sm_begin(input logic bp);
        sm_start  = 1'b1;
        sm_bypass = bp;
        tick();
        sm_start  = 1'b0;
        check("sm_busy_after_start", 32'(sm_busy), 32'd1);
    endtask

    // Enters in ACTIVE with an empty output register; returns in the done-pulse cycle.
    task automatic sm_words(input logic [6:0] d0, d1, e0, e1);
        sm_out_ready = 1'b1;
        sm_in_valid  = 1'b1;
        sm_in_data   = d0;
        tick();
        check("sm_w0_valid", 32'(sm_out_valid), 32'd1);
        check("sm_w0_data", 32'(sm_out_data), 32'(e0));
        check("sm_w0_last", 32'(sm_out_last), 32'd0);
        sm_in_data = d1;
        tick();
        sm_in_valid = 1'b0;
        check("sm_w1_data", 32'(sm_out_data), 32'(e1));
        check("sm_w1_last", 32'(sm_out_last), 32'd1);
        check("sm_drain_in_ready", 32'(sm_in_ready), 32'd0);
        check("sm_done_early", 32'(sm_done), 32'd0);
        tick();
        check("sm_done_pulse", 32'(sm_done), 32'd1);
        check("sm_busy_at_done", 32'(sm_busy), 32'd0);
        check("sm_empty_at_done", 32'(sm_out_valid), 32'd0);
    endtask

    // ---------------- default-config drivers ----------------
    task automatic partial_frame_then_reset();
        logic [19:0] r0, r1;
        r0 = ks_step(D_SEED);
        r1 = ks_step(r0[19:8]);
        def_start = 1'b1;
        tick();
        def_start    = 1'b0;
        def_in_valid = 1'b1;
        def_in_data  = 8'h00;
        tick();
        check("rst_w0_valid", 32'(def_out_valid), 32'd1);
        check("rst_w0_golden", 32'(def_out_data), 32'h9F);
        tick();
        check("rst_w1_model", 32'(def_out_data), 32'(r1[7:0]));
        check("rst_lb_w0", 32'(lb_out_data), 32'h00);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(def_out_valid), 32'd0);
        check("rst_busy", 32'(def_busy), 32'd0);
        check("rst_in_ready", 32'(def_in_ready), 32'd0);
        check("rst_out_data", 32'(def_out_data), 32'd0);
        check("rst_lb_busy", 32'(lb_busy), 32'd0);
        def_in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic run_def_frame(input logic stalls, input logic pulses, input logic zero_first);
        logic [7:0]  data_a[D_LEN];
        logic [11:0] s;
        logic [19:0] r;
        logic        acc;
        int          n;
        s = D_SEED;
        for (int i = 0; i < D_LEN; i++) begin
            data_a[i] = (zero_first && i == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            r = ks_step(s);
            s = r[19:8];
            def_exp_q.push_back(data_a[i] ^ r[7:0]);
            lb_exp_q.push_back(data_a[i]);
        end
        def_word_idx = 0;
        lb_words     = 0;
        def_done_cnt = 0;
        lb_done_cnt  = 0;
        rand_en      = stalls;
        def_start    = 1'b1;
        tick();
        def_start = 1'b0;
        for (int i = 0; i < D_LEN; i++) begin
            def_in_valid = 1'b1;
            def_in_data  = data_a[i];
            acc = 1'b0;
            n   = 0;
            while (!acc && n < 500) begin
                @(negedge clk);
                acc = def_in_ready;
                tick();
                def_start = pulses && def_busy && 1'($urandom_range(0, 1));
                n++;
            end
            if (!acc) begin
                check("def_accept_timeout", 32'(acc), 32'd1);
                break;
            end
        end
        def_in_valid = 1'b0;
        n = 0;
        while (lb_done_cnt == 0 && n < 2000) begin
            tick();
            def_start = pulses && def_busy && 1'($urandom_range(0, 1));
            n++;
        end
        def_start = 1'b0;
        rand_en   = 1'b0;
        tick();
        tick();
        check("frame_def_words", 32'(def_word_idx), 32'(D_LEN));
        check("frame_lb_words", 32'(lb_words), 32'(D_LEN));
        check("frame_def_done", 32'(def_done_cnt), 32'd1);
        check("frame_lb_done", 32'(lb_done_cnt), 32'd1);
        check("frame_def_q_empty", 32'(def_exp_q.size()), 32'd0);
        check("frame_lb_q_empty", 32'(lb_exp_q.size()), 32'd0);
        check("frame_def_idle", 32'(def_busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        sm_vec_t vecs[6];
        vecs[0] = '{bp: 1'b0, d0: 7'h00, d1: 7'h00, e0: 7'h4E, e1: 7'h4E};
        vecs[1] = '{bp: 1'b1, d0: 7'h15, d1: 7'h2A, e0: 7'h15, e1: 7'h2A};
        vecs[2] = '{bp: 1'b0, d0: 7'h00, d1: 7'h00, e0: 7'h4E, e1: 7'h4E};
        vecs[3] = '{bp: 1'b0, d0: 7'h7F, d1: 7'h01, e0: 7'h31, e1: 7'h4F};
        vecs[4] = '{bp: 1'b1, d0: 7'h7F, d1: 7'h00, e0: 7'h7F, e1: 7'h00};
        vecs[5] = '{bp: 1'b0, d0: 7'h4E, d1: 7'h0F, e0: 7'h00, e1: 7'h41};

        // Reset state
        #12;
        check("reset_sm_out_valid", 32'(sm_out_valid), 32'd0);
        check("reset_sm_out_data", 32'(sm_out_data), 32'd0);
        check("reset_sm_in_ready", 32'(sm_in_ready), 32'd0);
        check("reset_sm_busy", 32'(sm_busy), 32'd0);
        check("reset_sm_done", 32'(sm_done), 32'd0);
        check("reset_def_last", 32'(def_out_last), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Small configuration: table of frames
        for (int v = 0; v < 6; v++) begin
            sm_begin(vecs[v].bp);
            sm_words(vecs[v].d0, vecs[v].d1, vecs[v].e0, vecs[v].e1);
            tick();
            check("sm_done_one_cycle", 32'(sm_done), 32'd0);
        end

        // Start held high across a whole frame: ignored in ACTIVE/DRAIN and in the done cycle
        sm_start = 1'b1;
        tick();
        check("sm_hold_start_busy", 32'(sm_busy), 32'd1);
        sm_words(7'h00, 7'h00, 7'h4E, 7'h4E);
        tick();
        check("sm_start_in_done_ignored", 32'(sm_busy), 32'd0);
        tick();
        check("sm_held_start_restarts", 32'(sm_busy), 32'd1);
        sm_start = 1'b0;
        sm_words(7'h00, 7'h00, 7'h4E, 7'h4E);
        tick();

        // Asynchronous reset mid-frame, twice, each followed by a reseeded first word
        partial_frame_then_reset();
        partial_frame_then_reset();

        // in_valid while IDLE is ignored
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            def_in_valid = 1'b1;
            def_in_data  = 8'($urandom_range(0, 255));
            tick();
            check("idle_in_ready", 32'(def_in_ready), 32'd0);
            check("idle_out_valid", 32'(def_out_valid), 32'd0);
            check("idle_busy", 32'(def_busy), 32'd0);
        end
        def_in_valid = 1'b0;

        // Full frames: clean loopback, then random stalls, then stalls with stray starts
        run_def_frame(1'b0, 1'b0, 1'b1);
        run_def_frame(1'b1, 1'b0, 1'b0);
        run_def_frame(1'b1, 1'b1, 1'b1);
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
